regfile_dump: RTL and testbench

Debug reader for the processor register file. On a start pulse it walks a contiguous, optionally wrapping, range of register indices through a register-file read port. It captures each value and streams it out as index/data words over a valid/ready handshake. It sits between the register file's Rs read port, which is muxed to it while the core is halted, and the debug/UART transmit path.

---
 rtl/regfile_dump.sv | 79 +++++++
 tb/tb_regfile_dump.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug reader that walks a wrapping range of register-file indices through the Rs port
// and streams index/data words out over a valid/ready handshake.
module regfile_dump #(
    parameter int unsigned REGBITS = 5,
    parameter int unsigned WIDTH   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [REGBITS-1:0] firstReg,
    input  logic [REGBITS-1:0] lastReg,
    output logic [REGBITS-1:0] Rs,
    input  logic [WIDTH-1:0]   RsData,
    output logic [WIDTH-1:0]   outData,
    output logic [REGBITS-1:0] outIndex,
    output logic               outValid,
    input  logic               outReady,
    output logic               busy,
    output logic               done
);

    // All four encodings are live states, so no lockup encoding exists.
    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e             state_q;
    logic [REGBITS-1:0] idx_q;
    logic [REGBITS-1:0] end_idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            end_idx_q <= '0;
            outData   <= '0;
            outIndex  <= '0;
        end else if (abort) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q     <= firstReg;
                        end_idx_q <= lastReg;
                        state_q   <= StRead;
                    end
                end
                StRead: begin
                    outData  <= RsData;
                    outIndex <= idx_q;
                    state_q  <= StSend;
                end
                StSend: begin
                    if (outReady) begin
                        if (idx_q == end_idx_q) begin
                            state_q <= StDone;
                        end else begin
                            // Natural wrap at 1<<REGBITS gives the lastReg < firstReg case.
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StRead;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Rs       = (state_q == StIdle) ? '0 : idx_q;
    assign outValid = (state_q == StSend);
    assign done     = (state_q == StDone);
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: range table plus back-pressure, abort, reset and
// write-during-dump sequences, all words checked through a scoreboard queue.
module tb_regfile_dump;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         words;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  firstReg;
    logic [4:0]  lastReg;
    logic [4:0]  Rs;
    logic [31:0] RsData;
    logic [31:0] outData;
    logic [4:0]  outIndex;
    logic        outValid;
    logic        outReady;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    sb_t         exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    regfile_dump #(.REGBITS(5), .WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .firstReg (firstReg),
        .lastReg  (lastReg),
        .Rs       (Rs),
        .RsData   (RsData),
        .outData  (outData),
        .outIndex (outIndex),
        .outValid (outValid),
        .outReady (outReady),
        .busy     (busy),
        .done     (done)
    );

    // Register file model: register 0 reads as zero.
    assign RsData = (Rs == 5'd0) ? 32'd0 : regs[Rs];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : regs[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [4:0] first, input logic [4:0] last);
        logic [4:0] i;
        logic [4:0] span;
        i    = first;
        span = last - first;
        for (int k = 0; k <= 32'(span); k++) begin
            exp_q.push_back('{idx: i, data: model(i)});
            i = i + 5'd1;
        end
    endtask

    task automatic pulse_start(input logic [4:0] first, input logic [4:0] last);
        firstReg = first;
        lastReg  = last;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int seen;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt != d0) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_valid();
        int seen;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (outValid) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("valid_seen", 32'(seen), 32'd1);
    endtask

    // Monitor: sample mid-cycle; valid&ready here means a handshake at the coming edge.
    always @(negedge clk) begin
        sb_t e;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (outValid && outReady && reset) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got idx %0d data 0x%08h, expected no word",
                         outIndex, outData);
            end else begin
                e = exp_q.pop_front();
                check("word_index", 32'(outIndex), 32'(e.idx));
                check("word_data", outData, e.data);
            end
        end
    end

    initial begin
        vec_t vecs [5];
        int   hs0;
        int   d0;
        int   b0;
        int   found;

        vecs[0] = '{first: 5'd0,  last: 5'd31, words: 32};
        vecs[1] = '{first: 5'd30, last: 5'd1,  words: 4};
        vecs[2] = '{first: 5'd7,  last: 5'd7,  words: 1};
        vecs[3] = '{first: 5'd5,  last: 5'd9,  words: 5};
        vecs[4] = '{first: 5'd31, last: 5'd0,  words: 2};

        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        firstReg = 5'd0;
        lastReg  = 5'd0;
        outReady = 1'b1;
        #1;
        check("rst_rs", 32'(Rs), 32'd0);
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", outData, 32'd0);
        check("rst_index", 32'(outIndex), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Range table, outReady held high.
        foreach (vecs[v]) begin
            outReady = 1'b1;
            hs0 = hs_cnt;
            d0  = done_cnt;
            b0  = busy_cnt;
            push_range(vecs[v].first, vecs[v].last);
            pulse_start(vecs[v].first, vecs[v].last);
            check("start_rs", 32'(Rs), 32'(vecs[v].first));
            wait_done(d0);
            check("range_words", 32'(hs_cnt - hs0), 32'(vecs[v].words));
            check("range_busy_cycles", 32'(busy_cnt - b0), 32'(2 * vecs[v].words + 1));
            check("range_done_pulses", 32'(done_cnt - d0), 32'd1);
            check("range_idle", 32'(busy), 32'd0);
            check("range_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Back-pressure on a single word.
        outReady = 1'b0;
        hs0 = hs_cnt;
        d0  = done_cnt;
        push_range(5'd7, 5'd7);
        pulse_start(5'd7, 5'd7);
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(outValid), 32'd1);
            check("bp_data", outData, regs[7]);
            check("bp_index", 32'(outIndex), 32'd7);
            tick();
        end
        outReady = 1'b1;
        wait_done(d0);
        check("bp_words", 32'(hs_cnt - hs0), 32'd1);
        check("bp_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Abort on the third SEND; that word handshakes in the abort cycle.
        outReady = 1'b1;
        hs0 = hs_cnt;
        d0  = done_cnt;
        push_range(5'd0, 5'd2);
        pulse_start(5'd0, 5'd31);
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (outValid && hs_cnt == hs0 + 2) begin
                found = 1;
                break;
            end
            tick();
        end
        check("abort_third_send", 32'(found), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(outValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_words", 32'(hs_cnt - hs0), 32'd3);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        d0 = done_cnt;
        push_range(5'd3, 5'd4);
        pulse_start(5'd3, 5'd4);
        wait_done(d0);
        check("after_abort_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during SEND.
        outReady = 1'b0;
        pulse_start(5'd0, 5'd31);
        wait_valid();
        #2 reset = 1'b0;
        #1;
        check("arst_rs", 32'(Rs), 32'd0);
        check("arst_valid", 32'(outValid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_data", outData, 32'd0);
        check("arst_index", 32'(outIndex), 32'd0);
        tick();
        reset    = 1'b1;
        outReady = 1'b1;
        hs0 = hs_cnt;
        repeat (6) tick();
        check("arst_no_words", 32'(hs_cnt - hs0), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        // Write to reg 4 on the falling edge inside its READ; start held while busy.
        hs0 = hs_cnt;
        d0  = done_cnt;
        b0  = busy_cnt;
        for (int i = 2; i <= 6; i++) begin
            exp_q.push_back('{idx: 5'(i), data: (i == 4) ? 32'hDEAD_BEEF : model(5'(i))});
        end
        pulse_start(5'd2, 5'd6);
        firstReg = 5'd20;
        lastReg  = 5'd25;
        start    = 1'b1;
        found    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy && !outValid && !done && Rs == 5'd4) begin
                regs[4] = 32'hDEAD_BEEF;
                found = 1;
                break;
            end
        end
        check("wr_read4_seen", 32'(found), 32'd1);
        tick();
        tick();
        start = 1'b0;
        wait_done(d0);
        check("wr_words", 32'(hs_cnt - hs0), 32'd5);
        check("wr_busy_cycles", 32'(busy_cnt - b0), 32'd11);
        check("wr_done_pulses", 32'(done_cnt - d0), 32'd1);
        repeat (3) tick();
        check("wr_start_ignored", 32'(busy), 32'd0);
        check("wr_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
